// File: rtl/nibble_serial_adder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl_pkg
// Description : Shared state encodings and sizing helper for the nibble adder.
// Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Nibble index width; a single-nibble operand still needs a 1-bit index.
    function automatic int nib_idx_w(input int nib);
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl_if
// Description : Command/result handshake bundle between requester and adder.
// Revision    : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             sub;
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output start_valid, a_in, b_in, cin, sub, result_ready,
        input  start_ready, result_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  start_valid, a_in, b_in, cin, sub, result_ready,
        output start_ready, result_valid, sum, cout, ovf, busy
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl_bitfouradder.sv
`default_nettype none
// ============================================================================
// Module      : bitfouradder
// Description : 4-bit ripple-carry adder slice shared across all nibbles.
// Revision    : 1.0 - initial release
// ============================================================================
module bitfouradder (
    input  wire logic [3:0] a_i,
    input  wire logic [3:0] b_i,
    input  wire logic       ci_i,
    output logic      [3:0] s_o,
    output logic            co_o
);
    logic [4:0] carry_w;

    assign carry_w[0] = ci_i;

    for (genvar g = 0; g < 4; g++) begin : g_bit
        assign s_o[g]         = a_i[g] ^ b_i[g] ^ carry_w[g];
        assign carry_w[g + 1] = (a_i[g] & b_i[g]) | (carry_w[g] & (a_i[g] ^ b_i[g]));
    end

    assign co_o = carry_w[4];
endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder_ctrl
// Description : Multi-cycle WIDTH-bit add/sub, one nibble per clock, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    nibble_serial_adder_ctrl_if.slave bus
);
    localparam int                 NIB      = WIDTH / 4;
    localparam int                 IDX_W    = nib_idx_w(NIB);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NIB - 1);

    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;

    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [3:0]         s_nib;
    logic               co_nib;

    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4];

    bitfouradder u_slice (
        .a_i  (a_nib),
        .b_i  (b_nib),
        .ci_i (carry_q),
        .s_o  (s_nib),
        .co_o (co_nib)
    );

    // b_q holds the effective (possibly inverted) operand so RUN never looks at sub.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_valid) begin
                        a_q     <= bus.a_in;
                        b_q     <= bus.sub ? ~bus.b_in : bus.b_in;
                        carry_q <= bus.sub ? ~bus.cin  : bus.cin;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= s_nib;
                    carry_q                    <= co_nib;
                    idx_q                      <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= co_nib;
                        ovf_q   <= (a_nib[3] == b_nib[3]) & (s_nib[3] != a_nib[3]);
                        idx_q   <= '0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.result_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.start_ready  = (state_q == S_IDLE);
    assign bus.result_valid = (state_q == S_DONE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.sum          = sum_q;
    assign bus.cout         = cout_q;
    assign bus.ovf          = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder_ctrl
// Description : Directed + random bench with a result scoreboard for WIDTH=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    // Arithmetic reference written as plain wide add/subtract on unsigned values.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic c, input logic s);
        logic [WIDTH:0] r;
        exp_t           e;
        if (!s) begin
            r      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
            e.cout = r[WIDTH];
            e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        end else begin
            r      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c};
            e.cout = ~r[WIDTH];
            e.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
        end
        e.sum = r[WIDTH-1:0];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s, input int hold);
        exp_t             e;
        int               cnt;
        logic [WIDTH-1:0] held;
        @(negedge clk);
        chk("start_ready_idle", 32'(bus.start_ready), 32'd1);
        bus.start_valid = 1'b1;
        bus.a_in        = a;
        bus.b_in        = b;
        bus.cin         = c;
        bus.sub         = s;
        exp_q.push_back(model(a, b, c, s));
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        bus.a_in        = 16'($urandom);
        bus.b_in        = 16'($urandom);
        bus.cin         = 1'($urandom);
        bus.sub         = 1'($urandom);
        chk("busy_run", 32'(bus.busy), 32'd1);
        chk("start_ready_run", 32'(bus.start_ready), 32'd0);
        cnt = 0;
        while ((bus.result_valid !== 1'b1) && (cnt < 20)) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("latency", 32'(cnt), 32'(NIB));
        held = bus.sum;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.start_valid = 1'b1;
            bus.a_in        = 16'($urandom);
            @(posedge clk);
            #1;
            chk("hold_result_valid", 32'(bus.result_valid), 32'd1);
            chk("hold_sum_stable", 32'(bus.sum), 32'(held));
            chk("hold_start_ready", 32'(bus.start_ready), 32'd0);
        end
        bus.start_valid = 1'b0;
        @(negedge clk);
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sum", 32'(bus.sum), 32'(e.sum));
            chk("cout", 32'(bus.cout), 32'(e.cout));
            chk("ovf", 32'(bus.ovf), 32'(e.ovf));
            bus.result_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.result_ready = 1'b0;
            chk("valid_drop", 32'(bus.result_valid), 32'd0);
            chk("ready_back", 32'(bus.start_ready), 32'd1);
            chk("sum_retained", 32'(bus.sum), 32'(e.sum));
        end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        bus.start_valid  = 1'b0;
        bus.a_in         = '0;
        bus.b_in         = '0;
        bus.cin          = 1'b0;
        bus.sub          = 1'b0;
        bus.result_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_start_ready", 32'(bus.start_ready), 32'd1);
        chk("rst_result_valid", 32'(bus.result_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        rst = 1'b0;

        run_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op(16'h0009, 16'h0004, 1'b1, 1'b1, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        run_op(16'hABCD, 16'h5432, 1'b1, 1'b0, 5);

        // Abort mid-operation: reset lands on the edge ending the second RUN cycle.
        @(negedge clk);
        bus.start_valid = 1'b1;
        bus.a_in        = 16'h1111;
        bus.b_in        = 16'h2222;
        bus.cin         = 1'b0;
        bus.sub         = 1'b0;
        @(posedge clk);
        #1;
        bus.start_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_start_ready", 32'(bus.start_ready), 32'd1);
        chk("abort_result_valid", 32'(bus.result_valid), 32'd0);
        chk("abort_sum", 32'(bus.sum), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        repeat (NIB + 2) @(posedge clk);
        #1;
        chk("abort_no_result", 32'(bus.result_valid), 32'd0);

        run_op(16'h4321, 16'h1234, 1'b0, 1'b1, 0);

        for (int n = 0; n < 8; n++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0);
        end

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
